// File: rtl/gadget_manager.sv
// Power-up bookkeeping for the 16x16 arena: per-tile hidden/visible gadget state,
// explosion-edge reveal/destroy, and per-player bomb capacity / blast length pickups.
package gadget_pkg;
  localparam logic [2:0] G_EMPTY = 3'd0;
  localparam logic [2:0] G_HCAP  = 3'd1;
  localparam logic [2:0] G_HLEN  = 3'd2;
  localparam logic [2:0] G_VCAP  = 3'd3;
  localparam logic [2:0] G_VLEN  = 3'd4;
endpackage

module gadget_tile
  import gadget_pkg::*;
#(
  parameter logic [2:0] RST_VAL = G_EMPTY
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       exp_rise_i,
  input  logic       take_i,
  output logic [2:0] state_o
);
  logic [2:0] state_q, state_d;

  // A pickup beats a simultaneous blast edge; any other code under a blast becomes empty.
  always_comb begin
    state_d = state_q;
    if (take_i) state_d = G_EMPTY;
    else if (exp_rise_i) begin
      case (state_q)
        G_HCAP:  state_d = G_VCAP;
        G_HLEN:  state_d = G_VLEN;
        default: state_d = G_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RST_VAL;
    else     state_q <= state_d;
  end

  assign state_o = state_q;
endmodule

module gadget_manager
  import gadget_pkg::*;
#(
  parameter int INIT_CAP = 1,
  parameter int MAX_CAP  = 7,
  parameter int INIT_LEN = 1,
  parameter int MAX_LEN  = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   p1_cor,
  input  logic [7:0]   p2_cor,
  input  logic [255:0] i_explode,
  output logic [2:0]   o_p1_cap,
  output logic [2:0]   o_p2_cap,
  output logic [1:0]   o_p1_len,
  output logic [1:0]   o_p2_len,
  output logic [2:0]   o_gadget_state_grid [0:255],
  output logic         p2_able_to_add_bomb
);
  localparam int NUM_TILES = 256;
  localparam logic [2:0] CAP_MAX = 3'(MAX_CAP);
  localparam logic [1:0] LEN_MAX = 2'(MAX_LEN);

  function automatic logic [2:0] rst_layout(input int t);
    case (t)
      8'h22, 8'h4A, 8'h86, 8'hC3: return G_HCAP;
      8'h25, 8'h68, 8'hA9, 8'hDC: return G_HLEN;
      default:                    return G_EMPTY;
    endcase
  endfunction

  logic [NUM_TILES-1:0] explode_q, exp_rise, take;
  logic [2:0]           grid [0:NUM_TILES-1];
  logic [2:0]           p1_tile, p2_tile;
  logic                 p1_take, p2_take;
  logic [2:0]           p1_cap_q, p1_cap_d, p2_cap_q, p2_cap_d;
  logic [1:0]           p1_len_q, p1_len_d, p2_len_q, p2_len_d;
  logic                 p2_able_q;

  assign exp_rise = i_explode & ~explode_q;
  assign p1_tile  = grid[p1_cor];
  assign p2_tile  = grid[p2_cor];
  // P1 has priority when both stand on the same tile.
  assign p1_take  = (p1_tile == G_VCAP) || (p1_tile == G_VLEN);
  assign p2_take  = (p2_cor != p1_cor) && ((p2_tile == G_VCAP) || (p2_tile == G_VLEN));

  for (genvar g = 0; g < NUM_TILES; g++) begin : g_tile
    assign take[g] = (p1_take && (p1_cor == 8'(g))) || (p2_take && (p2_cor == 8'(g)));
    gadget_tile #(.RST_VAL(rst_layout(g))) u_tile (
      .clk        (clk),
      .rst        (rst),
      .exp_rise_i (exp_rise[g]),
      .take_i     (take[g]),
      .state_o    (grid[g])
    );
  end

  always_comb begin
    p1_cap_d = p1_cap_q;
    p2_cap_d = p2_cap_q;
    p1_len_d = p1_len_q;
    p2_len_d = p2_len_q;
    if (p1_take && p1_tile == G_VCAP && p1_cap_q < CAP_MAX) p1_cap_d = p1_cap_q + 3'd1;
    if (p1_take && p1_tile == G_VLEN && p1_len_q < LEN_MAX) p1_len_d = p1_len_q + 2'd1;
    if (p2_take && p2_tile == G_VCAP && p2_cap_q < CAP_MAX) p2_cap_d = p2_cap_q + 3'd1;
    if (p2_take && p2_tile == G_VLEN && p2_len_q < LEN_MAX) p2_len_d = p2_len_q + 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      explode_q <= '0;
      p1_cap_q  <= 3'(INIT_CAP);
      p2_cap_q  <= 3'(INIT_CAP);
      p1_len_q  <= 2'(INIT_LEN);
      p2_len_q  <= 2'(INIT_LEN);
      p2_able_q <= (INIT_CAP != MAX_CAP);
    end else begin
      explode_q <= i_explode;
      p1_cap_q  <= p1_cap_d;
      p2_cap_q  <= p2_cap_d;
      p1_len_q  <= p1_len_d;
      p2_len_q  <= p2_len_d;
      p2_able_q <= (p2_cap_d != CAP_MAX);
    end
  end

  assign o_p1_cap            = p1_cap_q;
  assign o_p2_cap            = p2_cap_q;
  assign o_p1_len            = p1_len_q;
  assign o_p2_len            = p2_len_q;
  assign p2_able_to_add_bomb = p2_able_q;
  assign o_gadget_state_grid = grid;
endmodule

// File: tb/tb_gadget_manager.sv
// Bench for gadget_manager: directed scenarios then random play, against a tile-map
// model. A second instance starts at capacity 6 so capacity saturation is reachable.
module tb_gadget_manager;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   p1_cor = '0, p2_cor = '0;
  logic [255:0] i_explode = '0;
  logic [2:0]   cap0 [2], cap1 [2];
  logic [1:0]   len0 [2], len1 [2];
  logic [2:0]   grid0 [0:255], grid1 [0:255];
  logic         able0, able1;

  always #5 clk = ~clk;

  gadget_manager dut (
    .clk(clk), .rst(rst), .p1_cor(p1_cor), .p2_cor(p2_cor), .i_explode(i_explode),
    .o_p1_cap(cap0[0]), .o_p2_cap(cap0[1]), .o_p1_len(len0[0]), .o_p2_len(len0[1]),
    .o_gadget_state_grid(grid0), .p2_able_to_add_bomb(able0));

  gadget_manager #(.INIT_CAP(6)) dut6 (
    .clk(clk), .rst(rst), .p1_cor(p1_cor), .p2_cor(p2_cor), .i_explode(i_explode),
    .o_p1_cap(cap1[0]), .o_p2_cap(cap1[1]), .o_p1_len(len1[0]), .o_p2_len(len1[1]),
    .o_gadget_state_grid(grid1), .p2_able_to_add_bomb(able1));

  int n_tests = 0, n_fail = 0;
  int gt[8] = '{8'h22, 8'h4A, 8'h86, 8'hC3, 8'h25, 8'h68, 8'hA9, 8'hDC};
  int init_cap[2] = '{1, 6};

  // model: tile codes 0 empty, 1/2 hidden cap/len, 3/4 visible cap/len
  int m_g[256];
  bit m_ex[256];
  int m_cap[2][2], m_len[2][2];

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [255:0] tile_bit(input int t);
    logic [255:0] v;
    v = '0;
    v[t] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    for (int t = 0; t < 256; t++) begin m_g[t] = 0; m_ex[t] = 0; end
    for (int k = 0; k < 4; k++) m_g[gt[k]] = 1;
    for (int k = 4; k < 8; k++) m_g[gt[k]] = 2;
    for (int i = 0; i < 2; i++)
      for (int p = 0; p < 2; p++) begin m_cap[i][p] = init_cap[i]; m_len[i][p] = 1; end
  endtask

  task automatic model_step(input logic [255:0] ex, input int a, input int b);
    int  ga, gb, nxt[256];
    bit  ta, tb;
    ga = m_g[a];
    gb = m_g[b];
    ta = (ga == 3 || ga == 4);
    tb = (b != a) && (gb == 3 || gb == 4);
    for (int t = 0; t < 256; t++) begin
      nxt[t] = m_g[t];
      if ((ta && t == a) || (tb && t == b)) nxt[t] = 0;
      else if (ex[t] && !m_ex[t]) nxt[t] = (m_g[t] == 1) ? 3 : (m_g[t] == 2) ? 4 : 0;
    end
    for (int i = 0; i < 2; i++) begin
      if (ta && ga == 3) m_cap[i][0] = min_i(m_cap[i][0] + 1, 7);
      if (ta && ga == 4) m_len[i][0] = min_i(m_len[i][0] + 1, 3);
      if (tb && gb == 3) m_cap[i][1] = min_i(m_cap[i][1] + 1, 7);
      if (tb && gb == 4) m_len[i][1] = min_i(m_len[i][1] + 1, 3);
    end
    for (int t = 0; t < 256; t++) begin m_g[t] = nxt[t]; m_ex[t] = ex[t]; end
  endtask

  task automatic check_all();
    for (int p = 0; p < 2; p++) begin
      chk("cap_i1", int'(cap0[p]), m_cap[0][p]);
      chk("len_i1", int'(len0[p]), m_len[0][p]);
      chk("cap_i6", int'(cap1[p]), m_cap[1][p]);
      chk("len_i6", int'(len1[p]), m_len[1][p]);
    end
    chk("able_i1", int'(able0), int'(m_cap[0][1] != 7));
    chk("able_i6", int'(able1), int'(m_cap[1][1] != 7));
    for (int t = 0; t < 256; t++) begin
      chk("grid_i1", int'(grid0[t]), m_g[t]);
      chk("grid_i6", int'(grid1[t]), m_g[t]);
    end
  endtask

  // Called at a falling edge: drive, advance model, then check at the next falling edge.
  task automatic cycle(input logic [255:0] ex, input logic [7:0] a, input logic [7:0] b);
    i_explode = ex;
    p1_cor    = a;
    p2_cor    = b;
    model_step(ex, int'(a), int'(b));
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_explode = '0;
    model_reset();
    #1;
    check_all();
    chk("rst_p1cap", int'(cap0[0]), 1);
    chk("rst_g22", int'(grid0[8'h22]), 1);
    @(negedge clk);
    rst = 1'b0;
    check_all();
  endtask

  initial begin
    logic [255:0] ex, prev;
    logic [7:0]   a, b;
    model_reset();
    @(negedge clk);
    check_all();
    chk("reset_p1cap", int'(cap0[0]), 1);
    chk("reset_p2len", int'(len0[1]), 1);
    chk("reset_g22", int'(grid0[8'h22]), 1);
    chk("reset_g25", int'(grid0[8'h25]), 2);
    chk("reset_g00", int'(grid0[0]), 0);
    chk("reset_able", int'(able0), 1);
    rst = 1'b0;

    // reveal by pulse and by held blast
    cycle(tile_bit(8'h22), 8'h00, 8'h00);
    cycle('0, 8'h00, 8'h00);
    chk("reveal_g22", int'(grid0[8'h22]), 3);
    for (int i = 0; i < 5; i++) cycle(tile_bit(8'h25), 8'h00, 8'h00);
    chk("held_g25", int'(grid0[8'h25]), 4);
    // pickups
    cycle('0, 8'h22, 8'h00);
    chk("pick_p1cap", int'(cap0[0]), 2);
    chk("pick_g22", int'(grid0[8'h22]), 0);
    cycle('0, 8'h00, 8'h25);
    chk("pick_p2len", int'(len0[1]), 2);
    // destroy by second edge
    cycle(tile_bit(8'h4A), 8'h00, 8'h00);
    cycle('0, 8'h00, 8'h00);
    cycle(tile_bit(8'h4A), 8'h00, 8'h00);
    chk("destroy_g4A", int'(grid0[8'h4A]), 0);
    chk("destroy_p1cap", int'(cap0[0]), 2);
    // contention, then pickup racing a new edge
    cycle(tile_bit(8'h86), 8'h00, 8'h00);
    cycle('0, 8'h86, 8'h86);
    chk("cont_p1cap", int'(cap0[0]), 3);
    chk("cont_p2cap", int'(cap0[1]), 1);
    cycle(tile_bit(8'hC3), 8'h00, 8'h00);
    cycle('0, 8'h00, 8'h00);
    cycle(tile_bit(8'hC3), 8'h00, 8'hC3);
    chk("race_p2cap", int'(cap0[1]), 2);
    chk("race_gC3", int'(grid0[8'hC3]), 0);
    chk("sat_p1cap6", int'(cap1[0]), 7);
    chk("sat_able6", int'(able1), 0);
    // length saturation
    cycle(tile_bit(8'h68) | tile_bit(8'hA9) | tile_bit(8'hDC), 8'h00, 8'h00);
    cycle('0, 8'h00, 8'h68);
    cycle('0, 8'h00, 8'hA9);
    cycle('0, 8'h00, 8'hDC);
    chk("sat_p2len", int'(len0[1]), 3);
    chk("sat_gDC", int'(grid0[8'hDC]), 0);
    // mid-game reset
    do_reset();

    prev = '0;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 39) == 0) begin
        do_reset();
        prev = '0;
        continue;
      end
      ex = '0;
      for (int k = 0; k < 8; k++)
        if ($urandom_range(0, 4) == 0 || (prev[gt[k]] && $urandom_range(0, 1) == 1)) ex[gt[k]] = 1'b1;
      if ($urandom_range(0, 3) == 0) ex[$urandom_range(0, 255)] = 1'b1;
      a = ($urandom_range(0, 1) == 1) ? 8'(gt[$urandom_range(0, 7)]) : 8'($urandom_range(0, 255));
      if ($urandom_range(0, 4) == 0) b = a;
      else b = ($urandom_range(0, 1) == 1) ? 8'(gt[$urandom_range(0, 7)]) : 8'($urandom_range(0, 255));
      cycle(ex, a, b);
      prev = ex;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
